acq_sequencer: RTL and testbench

Acquisition sequencer driven by the sync pulse from `signal_formatter`. It arms on a register command and waits for an accepted `start_pulse`. It then counts out a programmable delay and holds `capture_en` high for a programmed number of `sample_valid` strobes from the readout datapath. It timestamps each accepted trigger and counts sync pulses that arrive while it is busy. It sits between the sync-input formatter and the data-capture/packetizer stage, and is controlled from the register bank.

---
 rtl/acq_sequencer.sv | 174 +++++++++++++++++
 tb/tb_acq_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/acq_sequencer.sv
// rtl/acq_sequencer.sv - trigger-armed acquisition sequencer with delay, capture window and trigger stats
//
// Arms on a register command, accepts one start_pulse as a trigger, waits a
// programmable delay, then gates capture_en for a programmed number of
// sample_valid strobes. Accepted triggers are timestamped and counted;
// start_pulses that arrive while the sequence is running are counted as misses.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   arm, abort    one-cycle commands (abort has priority)
//   continuous    re-arm after each capture when latched high
//   delay_cfg     trigger-to-capture delay in clk cycles
//   length_cfg    samples per capture (0 behaves as 1)
//   start_pulse   sync pulse from the input formatter
//   sample_valid  sample strobe from the readout datapath
//   capture_en    registered capture window gate
//   busy          high in every state except IDLE
//   done          one-cycle pulse at the end of each capture
//   trig_time     timestamp of the last accepted trigger
//   trig_count    accepted triggers (wraps)
//   miss_count    triggers seen while busy (saturates)
module acq_sequencer #(
    parameter int DELAY_WIDTH = 16,
    parameter int LEN_WIDTH   = 32,
    parameter int TS_WIDTH    = 48,
    parameter int MISS_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm,
    input  logic                   abort,
    input  logic                   continuous,
    input  logic [DELAY_WIDTH-1:0] delay_cfg,
    input  logic [LEN_WIDTH-1:0]   length_cfg,
    input  logic                   start_pulse,
    input  logic                   sample_valid,
    output logic                   capture_en,
    output logic                   busy,
    output logic                   done,
    output logic [TS_WIDTH-1:0]    trig_time,
    output logic [31:0]            trig_count,
    output logic [MISS_WIDTH-1:0]  miss_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [DELAY_WIDTH-1:0] delay_sh;
    logic [DELAY_WIDTH-1:0] delay_cnt;
    logic [LEN_WIDTH-1:0]   len_sh;
    logic [LEN_WIDTH-1:0]   len_eff;
    logic [LEN_WIDTH-1:0]   sample_cnt;
    logic                   cont_sh;
    logic [TS_WIDTH-1:0]    ts;

    logic accept;
    logic latch;
    logic miss;
    logic last_sample;

    // A programmed length of zero still captures one sample.
    assign len_eff     = (len_sh == '0) ? LEN_WIDTH'(1) : len_sh;
    assign last_sample = sample_valid && ((sample_cnt + LEN_WIDTH'(1)) == len_eff);

    // Misses are judged on the current state, so the DONE cycle counts too.
    assign miss = start_pulse &&
                  ((state == S_DELAY) || (state == S_CAPTURE) || (state == S_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        latch      = 1'b0;
        case (state)
            S_IDLE: begin
                if (arm) begin
                    latch      = 1'b1;
                    state_next = S_ARMED;
                end
            end
            S_ARMED: begin
                if (start_pulse) begin
                    accept     = 1'b1;
                    state_next = (delay_sh == '0) ? S_CAPTURE : S_DELAY;
                end
            end
            S_DELAY: begin
                // delay_cnt enters at the shadow delay, so hitting 1 gives D cycles here
                if (delay_cnt <= DELAY_WIDTH'(1)) begin
                    state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (last_sample) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = cont_sh ? S_ARMED : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (abort) begin
            state_next = S_IDLE;
            accept     = 1'b0;
            latch      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            capture_en <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            trig_time  <= '0;
            trig_count <= '0;
            miss_count <= '0;
            ts         <= '0;
            delay_sh   <= '0;
            len_sh     <= '0;
            cont_sh    <= 1'b0;
            delay_cnt  <= '0;
            sample_cnt <= '0;
        end else begin
            // Status outputs are decoded from the next state so they line up with state.
            capture_en <= (state_next == S_CAPTURE);
            busy       <= (state_next != S_IDLE);
            done       <= (state_next == S_DONE);
            ts         <= ts + TS_WIDTH'(1);

            if (latch) begin
                delay_sh <= delay_cfg;
                len_sh   <= length_cfg;
                cont_sh  <= continuous;
            end

            if (accept) begin
                trig_time  <= ts;
                trig_count <= trig_count + 32'd1;
                delay_cnt  <= delay_sh;
            end else if (state == S_DELAY) begin
                delay_cnt <= delay_cnt - DELAY_WIDTH'(1);
            end

            if (state != S_CAPTURE) begin
                sample_cnt <= '0;
            end else if (sample_valid) begin
                sample_cnt <= sample_cnt + LEN_WIDTH'(1);
            end

            if (miss && (miss_count != '1)) begin
                miss_count <= miss_count + MISS_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_acq_sequencer.sv
// tb/tb_acq_sequencer.sv - directed self-checking bench for acq_sequencer
module tb_acq_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic        continuous = 1'b0;
    logic [15:0] delay_cfg = '0;
    logic [31:0] length_cfg = '0;
    logic        start_pulse = 1'b0;
    logic        sample_valid = 1'b0;
    logic        capture_en;
    logic        busy;
    logic        done;
    logic [47:0] trig_time;
    logic [31:0] trig_count;
    logic [15:0] miss_count;

    acq_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .arm          (arm),
        .abort        (abort),
        .continuous   (continuous),
        .delay_cfg    (delay_cfg),
        .length_cfg   (length_cfg),
        .start_pulse  (start_pulse),
        .sample_valid (sample_valid),
        .capture_en   (capture_en),
        .busy         (busy),
        .done         (done),
        .trig_time    (trig_time),
        .trig_count   (trig_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    // Reference timestamp: cycles since reset release.
    logic [47:0] tb_ts = '0;
    always @(posedge clk) tb_ts <= rst ? 48'd0 : tb_ts + 48'd1;

    int checks = 0;
    int failures = 0;

    int cyc, rise_cyc, done_cyc, qual, dones, sv_mode, phase, exp_trig;
    logic [47:0] t_exp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Observe the current cycle at the falling edge, then advance one clock.
    task automatic tick();
        @(negedge clk);
        if (capture_en && sample_valid) qual++;
        if (capture_en && rise_cyc < 0) rise_cyc = cyc;
        if (done) begin
            dones++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        phase++;
        sample_valid = (sv_mode == 2) || (sv_mode == 1 && phase[0]);
    endtask

    task automatic clear_obs();
        cyc = 0; rise_cyc = -1; done_cyc = -1; qual = 0; dones = 0;
    endtask

    task automatic do_arm(input logic [15:0] d, input logic [31:0] l, input logic c);
        delay_cfg = d; length_cfg = l; continuous = c; arm = 1'b1;
        tick();
        arm = 1'b0;
        delay_cfg = 16'hffff; length_cfg = 32'hffff_ffff; continuous = ~c;
    endtask

    task automatic pulse();
        start_pulse = 1'b1;
        t_exp = tb_ts;
        tick();
        start_pulse = 1'b0;
    endtask

    initial begin
        sv_mode = 0; phase = 0; exp_trig = 0;
        clear_obs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_capture_en", capture_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_trig_time", trig_time, 0);
        check("rst_trig_count", trig_count, 0);
        check("rst_miss_count", miss_count, 0);
        repeat (4) tick();

        // Single shot, delay 5, length 8, strobes every other cycle.
        sv_mode = 1;
        do_arm(16'd5, 32'd8, 1'b0);
        check("t1_busy_armed", busy, 1);
        clear_obs();
        pulse();
        exp_trig++;
        check("t1_trig_time", trig_time, t_exp);
        check("t1_trig_count", trig_count, exp_trig);
        for (int i = 0; i < 60; i++) tick();
        check("t1_rise", rise_cyc, 6);
        check("t1_samples", qual, 8);
        check("t1_dones", dones, 1);
        check("t1_busy_idle", busy, 0);

        // Delay 0, length 0.
        sv_mode = 2;
        do_arm(16'd0, 32'd0, 1'b0);
        clear_obs();
        pulse();
        exp_trig++;
        for (int i = 0; i < 10; i++) tick();
        check("t2_rise", rise_cyc, 1);
        check("t2_samples", qual, 1);
        check("t2_dones", dones, 1);
        check("t2_trig_count", trig_count, exp_trig);

        // Continuous, delay 2, length 4, three well-spaced triggers.
        do_arm(16'd2, 32'd4, 1'b1);
        clear_obs();
        for (int p = 0; p < 3; p++) begin
            pulse();
            exp_trig++;
            repeat (14) tick();
        end
        check("t3_dones", dones, 3);
        check("t3_samples", qual, 12);
        check("t3_trig_count", trig_count, exp_trig);
        check("t3_miss_count", miss_count, 0);

        // Extra pulses in DELAY (1), CAPTURE (4) and DONE (7).
        clear_obs();
        for (int k = 0; k < 12; k++) begin
            start_pulse = (k == 0 || k == 1 || k == 4 || k == 7);
            tick();
        end
        start_pulse = 1'b0;
        exp_trig++;
        check("t4_miss_count", miss_count, 3);
        check("t4_rise", rise_cyc, 3);
        check("t4_done_cyc", done_cyc, 7);
        check("t4_samples", qual, 4);
        check("t4_trig_count", trig_count, exp_trig);
        check("t4_busy_rearmed", busy, 1);

        // Saturation: hold the capture open and pulse continuously.
        sv_mode = 0;
        sample_valid = 1'b0;
        pulse();
        exp_trig++;
        start_pulse = 1'b1;
        for (int i = 0; i < 70000; i++) tick();
        start_pulse = 1'b0;
        check("t5_miss_sat", miss_count, 16'hffff);
        check("t5_capture_open", capture_en, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_abort_busy", busy, 0);
        check("t5_abort_capture_en", capture_en, 0);
        check("t5_trig_count", trig_count, exp_trig);

        // Abort after 3 of 10 samples, then a full capture.
        sv_mode = 2;
        do_arm(16'd1, 32'd10, 1'b0);
        clear_obs();
        pulse();
        exp_trig++;
        for (int i = 0; i < 40 && qual < 3; i++) tick();
        abort = 1'b1;
        sv_mode = 0;
        sample_valid = 1'b0;
        tick();
        abort = 1'b0;
        check("t6_abort_capture_en", capture_en, 0);
        check("t6_abort_busy", busy, 0);
        check("t6_abort_no_done", dones, 0);
        check("t6_abort_samples", qual, 3);
        sv_mode = 2;
        do_arm(16'd1, 32'd10, 1'b0);
        clear_obs();
        pulse();
        exp_trig++;
        for (int i = 0; i < 30; i++) tick();
        check("t6_full_samples", qual, 10);
        check("t6_full_dones", dones, 1);
        check("t6_trig_count", trig_count, exp_trig);

        // start_pulse in IDLE, then arm together with abort.
        pulse();
        check("t7_idle_pulse_count", trig_count, exp_trig);
        check("t7_idle_pulse_busy", busy, 0);
        arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        check("t7_arm_abort_busy", busy, 0);
        pulse();
        check("t7_after_count", trig_count, exp_trig);
        check("t7_after_miss", miss_count, 16'hffff);
        check("t7_after_busy", busy, 0);

        // Reset mid-capture.
        sv_mode = 0;
        sample_valid = 1'b0;
        do_arm(16'd0, 32'd10, 1'b0);
        clear_obs();
        pulse();
        tick();
        check("t8_pre_rst_capture_en", capture_en, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t8_rst_capture_en", capture_en, 0);
        check("t8_rst_busy", busy, 0);
        check("t8_rst_done", done, 0);
        check("t8_rst_trig_count", trig_count, 0);
        check("t8_rst_trig_time", trig_time, 0);
        check("t8_rst_miss_count", miss_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
